// File: rtl/rda_pkg.sv
// Shared constants and result layout for the RDA final sum stage.
// Lane status codes are the ASCII characters emitted by the carry pipeline.
package rda_pkg;

  localparam int W_DEF = 32;

  localparam logic [7:0] KPG_K = 8'h6B;
  localparam logic [7:0] KPG_G = 8'h67;
  localparam logic [7:0] KPG_P = 8'h70;

  localparam int RES_W_DEF = W_DEF + 2;

  typedef struct packed {
    logic [W_DEF-1:0] sum;
    logic             cout;
    logic             ovf;
  } rda_res_t;

  // Packed result width for an arbitrary operand width: {sum, cout, ovf}.
  function automatic int res_width(input int w);
    return w + 2;
  endfunction

  function automatic logic kpg_legal(input logic [7:0] code);
    return (code == KPG_K) || (code == KPG_G);
  endfunction

endpackage

// File: rtl/rda_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; push is accepted when full
// only if a pop happens in the same cycle.
module rda_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rda_sum_stage.sv
// Final RDA stage: decodes resolved K/P/G lane status into sum/cout/ovf,
// registers it once, and queues results in a valid/ready FIFO.
module rda_sum_stage
  import rda_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0][7:0]     y_kpg,
  input  logic [W-1:0]          a_q,
  input  logic [W-1:0]          b_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  afull,
  output logic                  drop_err,
  output logic                  kpg_err,
  output logic [CNT_W-1:0]      sum_count
);

  localparam int RES_W = res_width(W);
  localparam int AW    = $clog2(DEPTH);

  logic [W-1:0]     carry;
  logic [W-1:0]     cin;
  logic [W-1:0]     lane_bad;
  logic [W-1:0]     d_sum;
  logic             d_cout;
  logic             d_ovf;

  logic             s1_v;
  logic [RES_W-1:0] s1_res;

  logic [RES_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic             pop;
  logic             drop;

  // Anything other than 'g' contributes no carry; illegal lanes are flagged separately.
  always_comb begin
    carry    = '0;
    lane_bad = '0;
    for (int i = 0; i < W; i++) begin
      carry[i]    = (y_kpg[i] == KPG_G);
      lane_bad[i] = !kpg_legal(y_kpg[i]);
    end
  end

  assign cin    = {carry[W-2:0], 1'b0};
  assign d_sum  = a_q ^ b_q ^ cin;
  assign d_cout = carry[W-1];
  assign d_ovf  = cin[W-1] ^ carry[W-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      s1_res  <= '0;
      kpg_err <= 1'b0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) s1_res <= {d_sum, d_cout, d_ovf};
      if (in_valid && (|lane_bad)) kpg_err <= 1'b1;
    end
  end

  rda_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_v),
    .din   (s1_res),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = s1_v && fifo_full && !pop;
  assign afull     = (fifo_count >= (AW+1)'(DEPTH-1));

  // Head fields are forced low when empty so stale storage never shows after reset.
  assign sum  = out_valid ? head[RES_W-1:2] : '0;
  assign cout = out_valid ? head[1] : 1'b0;
  assign ovf  = out_valid ? head[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_err  <= 1'b0;
      sum_count <= '0;
    end else begin
      if (drop) drop_err <= 1'b1;
      if (pop)  sum_count <= sum_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rda_sum_stage.sv
// Directed bench for rda_sum_stage with hand-computed expected results.
module tb_rda_sum_stage;

  typedef logic [31:0][7:0] kpg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  kpg_t        y_kpg;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        afull;
  logic        drop_err;
  logic        kpg_err;
  logic [15:0] sum_count;

  int n_chk  = 0;
  int n_fail = 0;

  rda_sum_stage #(.W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .y_kpg     (y_kpg),
    .a_q       (a_q),
    .b_q       (b_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .afull     (afull),
    .drop_err  (drop_err),
    .kpg_err   (kpg_err),
    .sum_count (sum_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 'g' where gmask is set, 'k' elsewhere, optional 'p' on one lane.
  function automatic kpg_t mk_kpg(input logic [31:0] gmask, input int p_lane);
    kpg_t y;
    for (int i = 0; i < 32; i++) y[i] = gmask[i] ? 8'h67 : 8'h6B;
    if (p_lane >= 0) y[p_lane] = 8'h70;
    return y;
  endfunction

  task automatic drv(input logic [31:0] a, input logic [31:0] b, input kpg_t y, input logic v);
    a_q      = a;
    b_q      = b;
    y_kpg    = y;
    in_valid = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ov"},  out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_co"},  cout, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_af"},  afull, 0);
    chk({tag, "_drp"}, drop_err, 0);
    chk({tag, "_kpg"}, kpg_err, 0);
    chk({tag, "_cnt"}, sum_count, 0);
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    drv(0, 0, mk_kpg(0, -1), 1'b0);
    tick();
    tick();
    chk_all_zero("rst");
    rst = 1'b1;
    tick();

    // 1 + 1 with lane 0 generating
    out_ready = 1'b1;
    drv(32'h1, 32'h1, mk_kpg(32'h1, -1), 1'b1);
    tick();
    chk("t1_lat", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("t1_ov", out_valid, 1);
    chk("t1_sum", sum, 32'h2);
    chk("t1_co", cout, 0);
    chk("t1_ovf", ovf, 0);
    tick();
    chk("t1_cnt", sum_count, 1);
    chk("t1_empty", out_valid, 0);

    // carry wrap, then signed overflow
    drv(32'hFFFF_FFFF, 32'h1, mk_kpg(32'hFFFF_FFFF, -1), 1'b1);
    tick();
    drv(32'h7FFF_FFFF, 32'h7FFF_FFFF, mk_kpg(32'h7FFF_FFFF, -1), 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t2a_sum", sum, 32'h0);
    chk("t2a_co", cout, 1);
    chk("t2a_ovf", ovf, 0);
    tick();
    chk("t2b_sum", sum, 32'hFFFF_FFFE);
    chk("t2b_co", cout, 0);
    chk("t2b_ovf", ovf, 1);
    tick();
    chk("t2_empty", out_valid, 0);
    chk("t2_cnt", sum_count, 3);

    // unresolved 'p' lane: ignored when not valid, sticky when valid
    drv(32'h80, 32'h80, mk_kpg(0, 7), 1'b0);
    tick();
    tick();
    chk("t5_noval_err", kpg_err, 0);
    chk("t5_noval_ov", out_valid, 0);
    in_valid = 1'b1;
    tick();
    chk("t5_err", kpg_err, 1);
    in_valid = 1'b0;
    tick();
    chk("t5_ov", out_valid, 1);
    chk("t5_sum", sum, 32'h0);
    tick();
    tick();
    chk("t5_sticky", kpg_err, 1);
    chk("t5_cnt", sum_count, 4);

    // five back-to-back samples into a stalled FIFO
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drv(i, 0, mk_kpg(0, -1), 1'b1);
      tick();
      chk($sformatf("t3_af%0d", i), afull, (i - 1) >= 3);
      chk($sformatf("t3_drp%0d", i), drop_err, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("t3_drop", drop_err, 1);
    chk("t3_af_full", afull, 1);
    chk("t3_ov", out_valid, 1);
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("t3_pop%0d", v), sum, v);
      tick();
    end
    chk("t3_empty", out_valid, 0);
    chk("t3_cnt", sum_count, 8);

    // reset with three entries queued and one sample in the stage register
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drv(20 + i, 0, mk_kpg(0, -1), 1'b1);
      tick();
    end
    chk("t6_pre_af", afull, 1);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_all_zero("t6");
    rst = 1'b1;
    tick();
    chk("t6_s1_flush", out_valid, 0);
    tick();
    chk("t6_s1_flush2", out_valid, 0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i <= 4; i++) begin
      drv(10 + i, 0, mk_kpg(0, -1), 1'b1);
      tick();
    end
    chk("t4_full_af", afull, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_nodrop", drop_err, 0);
    chk("t4_af", afull, 1);
    chk("t4_ov", out_valid, 1);
    for (int v = 11; v <= 14; v++) begin
      chk($sformatf("t4_pop%0d", v), sum, v);
      tick();
    end
    chk("t4_empty", out_valid, 0);
    chk("t4_nodrop_end", drop_err, 0);
    chk("t4_cnt", sum_count, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
